// File: rtl/ofdm_cp_inserter.sv
// rtl/ofdm_cp_inserter.sv - cyclic-prefix inserter and symbol framer with ping-pong symbol buffer
module ofdm_cp_inserter #(
    parameter int DW     = 16,
    parameter int NFFT   = 64,
    parameter int CP_LEN = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [DW-1:0] i_in,
    input  logic [DW-1:0] q_in,
    input  logic          valid_in,
    input  logic          sop_in,
    output logic          ready_out,
    input  logic          cp_bypass,
    output logic [DW-1:0] i_OFDM,
    output logic [DW-1:0] q_OFDM,
    output logic          valid_OFDM,
    output logic          sop,
    output logic          eop,
    input  logic          ready_in,
    output logic          err_sync,
    output logic [15:0]   sym_cnt
);
    localparam int AW = $clog2(NFFT);
    localparam logic [AW-1:0] CP_START = AW'(NFFT - CP_LEN);
    localparam logic [AW-1:0] LAST     = AW'(NFFT - 1);

    typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} state_t;

    logic [2*DW-1:0] r_mem [0:2*NFFT-1];
    logic [1:0]      r_full;
    logic            r_wr_bank;
    logic [AW-1:0]   r_wr_cnt;
    state_t          r_state, w_state_n;
    logic            r_rd_bank, w_rd_bank_n;
    logic [AW-1:0]   r_rd_addr, w_rd_addr_n;
    logic            r_byp, w_byp_n;
    logic            w_in_beat, w_sop_err, w_nosop_err, w_we, w_wr_done;
    logic            w_load, w_clr, w_rd_sop, w_rd_eop, w_out_beat;
    logic [AW-1:0]   w_wr_addr;
    logic [1:0]      w_set, w_clr_mask;

    assign ready_out   = enable & ~reset & ~r_full[r_wr_bank];
    assign w_in_beat   = valid_in & ready_out;
    assign w_sop_err   = w_in_beat & sop_in & (r_wr_cnt != '0);
    assign w_nosop_err = w_in_beat & ~sop_in & (r_wr_cnt == '0);
    assign w_we        = w_in_beat & ~w_nosop_err;
    // A misplaced sop restarts the symbol: the sample lands at address 0.
    assign w_wr_addr   = w_sop_err ? '0 : r_wr_cnt;
    assign w_wr_done   = w_we & (w_wr_addr == LAST);
    assign w_set       = {w_wr_done & r_wr_bank, w_wr_done & ~r_wr_bank};
    assign w_clr_mask  = {w_clr & r_rd_bank, w_clr & ~r_rd_bank};
    assign w_out_beat  = enable & valid_OFDM & ready_in;

    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[{r_wr_bank, w_wr_addr}] <= {i_in, q_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_full    <= '0;
            err_sync  <= 1'b0;
        end else begin
            err_sync <= w_sop_err | w_nosop_err;
            r_full   <= (r_full & ~w_clr_mask) | w_set;
            if (w_we) begin
                if (w_wr_done) begin
                    r_wr_bank <= ~r_wr_bank;
                    r_wr_cnt  <= '0;
                end else begin
                    r_wr_cnt <= w_wr_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
            r_byp     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_rd_bank <= w_rd_bank_n;
            r_rd_addr <= w_rd_addr_n;
            r_byp     <= w_byp_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_rd_bank_n = r_rd_bank;
        w_rd_addr_n = r_rd_addr;
        w_byp_n     = r_byp;
        case (r_state)
            S_IDLE: begin
                if (enable && r_full[r_rd_bank]) begin
                    w_byp_n     = cp_bypass;
                    w_state_n   = cp_bypass ? S_BODY : S_CP;
                    w_rd_addr_n = cp_bypass ? '0 : CP_START;
                end
            end
            S_CP: begin
                if (w_load) begin
                    if (r_rd_addr == LAST) begin
                        w_state_n   = S_BODY;
                        w_rd_addr_n = '0;
                    end else begin
                        w_rd_addr_n = r_rd_addr + 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (w_load) begin
                    if (r_rd_addr == LAST) begin
                        w_rd_bank_n = ~r_rd_bank;
                        // Chain straight into the other bank when it is already full.
                        if (r_full[~r_rd_bank]) begin
                            w_byp_n     = cp_bypass;
                            w_state_n   = cp_bypass ? S_BODY : S_CP;
                            w_rd_addr_n = cp_bypass ? '0 : CP_START;
                        end else begin
                            w_state_n = S_IDLE;
                        end
                    end else begin
                        w_rd_addr_n = r_rd_addr + 1'b1;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        w_load   = enable & (r_state != S_IDLE) & (~valid_OFDM | ready_in);
        w_clr    = w_load & (r_state == S_BODY) & (r_rd_addr == LAST);
        w_rd_sop = ((r_state == S_CP) && (r_rd_addr == CP_START)) ||
                   ((r_state == S_BODY) && (r_rd_addr == '0) && r_byp);
        w_rd_eop = (r_state == S_BODY) && (r_rd_addr == LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            i_OFDM     <= '0;
            q_OFDM     <= '0;
            valid_OFDM <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            sym_cnt    <= '0;
        end else begin
            if (w_out_beat && eop) begin
                sym_cnt <= sym_cnt + 16'd1;
            end
            if (w_load) begin
                {i_OFDM, q_OFDM} <= r_mem[{r_rd_bank, r_rd_addr}];
                valid_OFDM       <= 1'b1;
                sop              <= w_rd_sop;
                eop              <= w_rd_eop;
            end else if (w_out_beat) begin
                valid_OFDM <= 1'b0;
                sop        <= 1'b0;
                eop        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// tb/tb_ofdm_cp_inserter.sv - self-checking bench for ofdm_cp_inserter
module tb_ofdm_cp_inserter;
    localparam int NFFT = 8;
    localparam int CPL  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] i_in = '0, q_in = '0;
    logic        valid_in = 1'b0, sop_in = 1'b0;
    logic        ready_out;
    logic        cp_bypass = 1'b0;
    logic [15:0] i_OFDM, q_OFDM;
    logic        valid_OFDM, sop, eop;
    logic        ready_in = 1'b1;
    logic        err_sync;
    logic [15:0] sym_cnt;

    ofdm_cp_inserter #(.DW(16), .NFFT(NFFT), .CP_LEN(CPL)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .i_in(i_in), .q_in(q_in), .valid_in(valid_in), .sop_in(sop_in),
        .ready_out(ready_out), .cp_bypass(cp_bypass),
        .i_OFDM(i_OFDM), .q_OFDM(q_OFDM), .valid_OFDM(valid_OFDM),
        .sop(sop), .eop(eop), .ready_in(ready_in),
        .err_sync(err_sync), .sym_cnt(sym_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct packed {
        logic        byp;
        logic        tog;
        logic [3:0]  n;
        logic [39:0] exp_i;
        logic [9:0]  exp_sop;
        logic [9:0]  exp_eop;
    } vec_t;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          stall_events = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [34:0] prev_out = '0;
    beat_t       rx[$];
    int          rx_cyc[$];
    beat_t       expq[$];
    logic [15:0] cur_i [0:NFFT-1];
    logic [15:0] cur_q [0:NFFT-1];
    vec_t        tbl [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0:       ready_in = 1'b1;
            1:       ready_in = ~ready_in;
            2:       ready_in = 1'b0;
            default: ready_in = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_events++;
                if ({i_OFDM, q_OFDM, sop, eop, valid_OFDM} !== prev_out) stall_viol++;
            end
            if (valid_OFDM && ready_in && enable) begin
                rx.push_back({i_OFDM, q_OFDM, sop, eop});
                rx_cyc.push_back(cyc);
            end
            prev_stall = valid_OFDM && !(ready_in && enable);
            prev_out   = {i_OFDM, q_OFDM, sop, eop, valid_OFDM};
        end
    end

    task automatic do_reset();
        reset = 1'b1; valid_in = 1'b0; sop_in = 1'b0; enable = 1'b1; rdy_mode = 0;
        repeat (2) begin @(posedge clock); #1; end
        chk("reset_state", {ready_out, valid_OFDM, sop, eop, err_sync, sym_cnt, i_OFDM, q_OFDM}, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        rx.delete(); rx_cyc.delete(); expq.delete();
        stall_events = 0; stall_viol = 0;
    endtask

    task automatic send_beat(input logic [15:0] si, input logic [15:0] sq, input logic s, input bit gaps);
        bit acc;
        int t;
        if (gaps && $urandom_range(0, 3) == 0) begin
            valid_in = 1'b0;
            enable = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            enable = 1'b1;
        end
        i_in = si; q_in = sq; sop_in = s; valid_in = 1'b1;
        acc = 1'b0; t = 0;
        while (!acc && t < 300) begin
            @(negedge clock);
            acc = ready_out;
            @(posedge clock); #1;
            t++;
        end
        if (!acc) chk("in_accept_timeout", 64'd0, 64'd1);
        valid_in = 1'b0; sop_in = 1'b0;
    endtask

    task automatic send_cur(input bit gaps);
        for (int k = 0; k < NFFT; k++) send_beat(cur_i[k], cur_q[k], k == 0, gaps);
    endtask

    task automatic rand_cur();
        for (int k = 0; k < NFFT; k++) begin
            cur_i[k] = 16'($urandom);
            cur_q[k] = 16'($urandom);
        end
    endtask

    // Expected output frame: CP tail (unless bypassed) followed by the whole symbol.
    task automatic push_model(input bit byp);
        beat_t b;
        if (!byp) begin
            for (int k = NFFT - CPL; k < NFFT; k++) begin
                b.i = cur_i[k]; b.q = cur_q[k]; b.sop = (k == NFFT - CPL); b.eop = 1'b0;
                expq.push_back(b);
            end
        end
        for (int k = 0; k < NFFT; k++) begin
            b.i = cur_i[k]; b.q = cur_q[k]; b.sop = byp && (k == 0); b.eop = (k == NFFT - 1);
            expq.push_back(b);
        end
    endtask

    task automatic wait_rx(input int n);
        int t;
        t = 0;
        while (rx.size() < n && t < 3000) begin
            @(posedge clock); #1;
            t++;
        end
        repeat (4) begin @(posedge clock); #1; end
    endtask

    task automatic compare_model(input string name);
        chk($sformatf("%s_count", name), 64'(rx.size()), 64'(expq.size()));
        for (int k = 0; k < rx.size() && k < expq.size(); k++)
            chk($sformatf("%s_beat%0d", name, k), 64'(rx[k]), 64'(expq[k]));
    endtask

    initial begin
        beat_t       eb;
        logic [15:0] ei;
        int          k_rdy;

        tbl[0] = '{1'b0, 1'b0, 4'd10, 40'h7654321076, 10'b0000000001, 10'b1000000000};
        tbl[1] = '{1'b1, 1'b0, 4'd8,  40'h0076543210, 10'b0000000001, 10'b0010000000};
        tbl[2] = '{1'b0, 1'b1, 4'd10, 40'h7654321076, 10'b0000000001, 10'b1000000000};
        tbl[3] = '{1'b1, 1'b1, 4'd8,  40'h0076543210, 10'b0000000001, 10'b0010000000};

        for (int r = 0; r < 4; r++) begin
            do_reset();
            cp_bypass = tbl[r].byp;
            rdy_mode = tbl[r].tog ? 1 : 0;
            for (int k = 0; k < NFFT; k++) begin
                cur_i[k] = 16'(k);
                cur_q[k] = 16'(-k);
            end
            send_cur(1'b0);
            if (!tbl[r].tog) begin
                @(posedge clock); #1;
                chk($sformatf("row%0d_latency_c1_valid", r), 64'(valid_OFDM), 64'd0);
                @(posedge clock); #1;
                chk($sformatf("row%0d_latency_c2_valid_sop", r), 64'({valid_OFDM, sop}), 64'd3);
            end
            wait_rx(int'(tbl[r].n));
            chk($sformatf("row%0d_count", r), 64'(rx.size()), 64'(tbl[r].n));
            for (int k = 0; k < int'(tbl[r].n); k++) begin
                if (k < rx.size()) begin
                    ei = {12'd0, tbl[r].exp_i[k*4 +: 4]};
                    eb.i = ei; eb.q = 16'd0 - ei;
                    eb.sop = tbl[r].exp_sop[k]; eb.eop = tbl[r].exp_eop[k];
                    chk($sformatf("row%0d_beat%0d", r, k), 64'(rx[k]), 64'(eb));
                end
            end
            chk($sformatf("row%0d_sym_cnt", r), 64'(sym_cnt), 64'd1);
            if (tbl[r].tog) begin
                chk($sformatf("row%0d_stalled", r), 64'(stall_events > 0), 64'd1);
                chk($sformatf("row%0d_stall_hold", r), 64'(stall_viol), 64'd0);
            end
        end

        // Four back-to-back symbols must stream out without a gap.
        do_reset();
        cp_bypass = 1'b0;
        for (int s = 0; s < 4; s++) begin
            rand_cur();
            send_cur(1'b0);
            push_model(1'b0);
        end
        wait_rx(40);
        compare_model("b2b");
        if (rx_cyc.size() >= 40) chk("b2b_gapless", 64'(rx_cyc[39] - rx_cyc[0]), 64'd39);
        chk("b2b_sym_cnt", 64'(sym_cnt), 64'd4);

        // Both banks full under backpressure throttle the input side.
        do_reset();
        rdy_mode = 2;
        for (int s = 0; s < 2; s++) begin
            rand_cur();
            send_cur(1'b0);
            push_model(1'b0);
        end
        @(posedge clock); #1;
        chk("full_ready_out_low", 64'(ready_out), 64'd0);
        rdy_mode = 0;
        k_rdy = 0;
        while (!ready_out && k_rdy < 40) begin
            @(posedge clock); #1;
            k_rdy++;
        end
        chk("full_release_window", 64'(k_rdy >= 5 && k_rdy <= 15), 64'd1);
        wait_rx(20);
        compare_model("full");

        // Framing errors, preceded by a mid-frame reset.
        do_reset();
        for (int k = 0; k < 3; k++) send_beat(16'(200 + k), 16'(k), k == 0, 1'b0);
        do_reset();
        for (int k = 0; k < 5; k++) send_beat(16'(10 + k), 16'(k), k == 0, 1'b0);
        chk("frame_no_err_normal", 64'(err_sync), 64'd0);
        send_beat(16'd100, 16'(-100), 1'b1, 1'b0);
        chk("frame_sop_err_pulse", 64'(err_sync), 64'd1);
        @(posedge clock); #1;
        chk("frame_sop_err_one_cycle", 64'(err_sync), 64'd0);
        for (int k = 1; k < NFFT; k++) send_beat(16'(100 + k), 16'(-(100 + k)), 1'b0, 1'b0);
        send_beat(16'd50, 16'd50, 1'b0, 1'b0);
        chk("frame_nosop_err_pulse", 64'(err_sync), 64'd1);
        for (int k = 0; k < NFFT; k++) begin
            cur_i[k] = 16'(100 + k);
            cur_q[k] = 16'(-(100 + k));
        end
        push_model(1'b0);
        wait_rx(10);
        compare_model("frame");
        chk("frame_sym_cnt", 64'(sym_cnt), 64'd1);

        // Random data, random backpressure, input gaps and enable freezes.
        for (int run = 0; run < 2; run++) begin
            do_reset();
            cp_bypass = 1'(run);
            rdy_mode = 3;
            for (int s = 0; s < 10; s++) begin
                rand_cur();
                send_cur(1'b1);
                push_model(1'(run));
            end
            wait_rx(expq.size());
            compare_model($sformatf("rand%0d", run));
            chk($sformatf("rand%0d_sym_cnt", run), 64'(sym_cnt), 64'd10);
            chk($sformatf("rand%0d_stall_hold", run), 64'(stall_viol), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
